// File: rtl/pae32_mmu_pkg.sv
// Shared constants, PTE field positions and walker state encoding for the PAE32 MMU.
package pae32_mmu_pkg;

  localparam int unsigned CSR_AW  = 3;
  localparam int unsigned VPN_W   = 8;
  localparam int unsigned PAE_W   = 16;
  localparam int unsigned HUGE_W  = 11;
  localparam int unsigned TLB_W   = VPN_W + PAE_W;

  localparam logic [CSR_AW-1:0] CSR_CTRL   = 3'd0;
  localparam logic [CSR_AW-1:0] CSR_PTBR   = 3'd1;
  localparam logic [CSR_AW-1:0] CSR_HUGE   = 3'd2;
  localparam logic [CSR_AW-1:0] CSR_ITLB   = 3'd3;
  localparam logic [CSR_AW-1:0] CSR_DTLB   = 3'd4;
  localparam logic [CSR_AW-1:0] CSR_FAULT  = 3'd5;
  localparam logic [CSR_AW-1:0] CSR_STATUS = 3'd6;

  localparam int unsigned PTE_V       = 31;
  localparam int unsigned PTE_X       = 30;
  localparam int unsigned PTE_PAE_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } ptw_state_e;

  // Identifies one walk: which side missed and the missing vpn.
  typedef struct packed {
    logic             side;  // 1 = data
    logic [VPN_W-1:0] vpn;
  } walk_tag_t;

endpackage

// File: rtl/pae32_ptw_csr.sv
// CSR register file and read mux holding all translation state the MMU consumes.
module pae32_ptw_csr
  import pae32_mmu_pkg::*;
#(
  parameter int unsigned TBL_ALIGN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  input  logic              walk_busy,
  input  logic              upd_i,
  input  logic              upd_d,
  input  logic [VPN_W-1:0]  upd_pte,
  input  logic [PAE_W-1:0]  upd_pae,
  input  logic              flt_load,
  input  walk_tag_t         flt_tag,
  output logic              mmu_enable,
  output logic [31:0]       ptbr,
  output logic [HUGE_W-1:0] hugepage_ptr,
  output logic [PAE_W-1:0]  ipae_h16,
  output logic [VPN_W-1:0]  ipte_h8,
  output logic [PAE_W-1:0]  dpae_h16,
  output logic [VPN_W-1:0]  dpte_h8
);

  localparam logic [31:0] PTBR_MASK = ~((32'd1 << TBL_ALIGN) - 32'd1);

  logic              en_q, en_d;
  logic [31:0]       ptbr_q, ptbr_d;
  logic [HUGE_W-1:0] huge_q, huge_d;
  logic [TLB_W-1:0]  itlb_q, itlb_d;
  logic [TLB_W-1:0]  dtlb_q, dtlb_d;
  walk_tag_t         fault_q, fault_d;

  // Walk updates first, CSR writes last so software wins a same-edge collision.
  always_comb begin
    en_d    = en_q;
    ptbr_d  = ptbr_q;
    huge_d  = huge_q;
    itlb_d  = itlb_q;
    dtlb_d  = dtlb_q;
    fault_d = fault_q;
    if (upd_i)    itlb_d  = {upd_pte, upd_pae};
    if (upd_d)    dtlb_d  = {upd_pte, upd_pae};
    if (flt_load) fault_d = flt_tag;
    if (csr_we) begin
      case (csr_addr)
        CSR_CTRL: en_d   = csr_wdata[0];
        CSR_PTBR: ptbr_d = csr_wdata & PTBR_MASK;
        CSR_HUGE: huge_d = csr_wdata[HUGE_W-1:0];
        CSR_ITLB: itlb_d = csr_wdata[TLB_W-1:0];
        CSR_DTLB: dtlb_d = csr_wdata[TLB_W-1:0];
        default:  ;
      endcase
    end
  end

  // Register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      ptbr_q  <= '0;
      huge_q  <= '0;
      itlb_q  <= '0;
      dtlb_q  <= '0;
      fault_q <= '0;
    end else begin
      en_q    <= en_d;
      ptbr_q  <= ptbr_d;
      huge_q  <= huge_d;
      itlb_q  <= itlb_d;
      dtlb_q  <= dtlb_d;
      fault_q <= fault_d;
    end
  end

  // Combinational read mux; unused bits and unmapped indices read 0.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_CTRL:   csr_rdata = {31'b0, en_q};
      CSR_PTBR:   csr_rdata = ptbr_q;
      CSR_HUGE:   csr_rdata = 32'(huge_q);
      CSR_ITLB:   csr_rdata = 32'(itlb_q);
      CSR_DTLB:   csr_rdata = 32'(dtlb_q);
      CSR_FAULT:  csr_rdata = 32'(fault_q);
      CSR_STATUS: csr_rdata = {31'b0, walk_busy};
      default:    csr_rdata = '0;
    endcase
  end

  assign mmu_enable   = en_q;
  assign ptbr         = ptbr_q;
  assign hugepage_ptr = huge_q;
  assign ipae_h16     = itlb_q[PAE_W-1:0];
  assign ipte_h8      = itlb_q[TLB_W-1:PAE_W];
  assign dpae_h16     = dtlb_q[PAE_W-1:0];
  assign dpte_h8      = dtlb_q[TLB_W-1:PAE_W];

endmodule

// File: rtl/pae32_ptw.sv
// Single-level page-table walker: fetches one PTE per miss and refills or faults.
module pae32_ptw
  import pae32_mmu_pkg::*;
#(
  parameter int unsigned TBL_ALIGN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_we,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  input  logic              i_miss,
  input  logic              d_miss,
  input  logic [VPN_W-1:0]  i_vpn,
  input  logic [VPN_W-1:0]  d_vpn,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [PAE_W-1:0]  ipae_h16,
  output logic [PAE_W-1:0]  dpae_h16,
  output logic [VPN_W-1:0]  ipte_h8,
  output logic [VPN_W-1:0]  dpte_h8,
  output logic [HUGE_W-1:0] hugepage_ptr,
  output logic              mmu_enable,
  output logic              walk_busy,
  output logic              refill_done,
  output logic              pf_i,
  output logic              pf_d
);

  ptw_state_e  state_q, state_d;
  walk_tag_t   tag_q, tag_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pf_i_q, pf_i_d;
  logic        pf_d_q, pf_d_d;

  logic        pte_ok_c;
  logic        upd_i_c, upd_d_c, flt_load_c;
  logic [31:0] ptbr;
  logic        unused_rdata;

  assign unused_rdata = ^mem_rdata[PTE_X-1:PTE_PAE_MSB+1];

  pae32_ptw_csr #(
    .TBL_ALIGN (TBL_ALIGN)
  ) u_csr (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .walk_busy    (busy_q),
    .upd_i        (upd_i_c),
    .upd_d        (upd_d_c),
    .upd_pte      (tag_q.vpn),
    .upd_pae      (mem_rdata[PTE_PAE_MSB:0]),
    .flt_load     (flt_load_c),
    .flt_tag      (tag_q),
    .mmu_enable   (mmu_enable),
    .ptbr         (ptbr),
    .hugepage_ptr (hugepage_ptr),
    .ipae_h16     (ipae_h16),
    .ipte_h8      (ipte_h8),
    .dpae_h16     (dpae_h16),
    .dpte_h8      (dpte_h8)
  );

  // Walker next-state, update strobes and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    pf_i_d     = 1'b0;
    pf_d_d     = 1'b0;
    upd_i_c    = 1'b0;
    upd_d_c    = 1'b0;
    flt_load_c = 1'b0;
    pte_ok_c   = mem_rdata[PTE_V] && (tag_q.side || mem_rdata[PTE_X]);

    case (state_q)
      ST_IDLE: begin
        if (mmu_enable && (d_miss || i_miss)) begin
          state_d    = ST_WALK;
          tag_d.side = d_miss;
          tag_d.vpn  = d_miss ? d_vpn : i_vpn;
          mem_addr_d = ptbr | 32'({tag_d.vpn, 2'b00});
        end
      end
      ST_WALK: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (pte_ok_c) begin
            upd_d_c = tag_q.side;
            upd_i_c = !tag_q.side;
            done_d  = 1'b1;
          end else begin
            flt_load_c = 1'b1;
            pf_d_d     = tag_q.side;
            pf_i_d     = !tag_q.side;
          end
        end else if (!mmu_enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_DRAIN: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d == ST_WALK) || (state_d == ST_DRAIN);
    busy_d    = (state_d != ST_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pf_i_q     <= 1'b0;
      pf_d_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pf_i_q     <= pf_i_d;
      pf_d_q     <= pf_d_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign walk_busy   = busy_q;
  assign refill_done = done_q;
  assign pf_i        = pf_i_q;
  assign pf_d        = pf_d_q;

endmodule

// File: tb/tb_pae32_ptw.sv
// Randomized self-checking bench for pae32_ptw against a CSR-level reference model.
`timescale 1ns/1ps
module tb_pae32_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [2:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        i_miss, d_miss;
  logic [7:0]  i_vpn, d_vpn;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] ipae_h16, dpae_h16;
  logic [7:0]  ipte_h8, dpte_h8;
  logic [10:0] hugepage_ptr;
  logic        mmu_enable, walk_busy, refill_done, pf_i, pf_d;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural CSR contents.
  logic        m_en;
  logic [31:0] m_ptbr;
  logic [10:0] m_huge;
  logic [23:0] m_itlb, m_dtlb;
  logic [8:0]  m_fault;

  pae32_ptw #(.TBL_ALIGN(10)) dut (
    .clk(clk), .rst(rst),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .i_miss(i_miss), .d_miss(d_miss), .i_vpn(i_vpn), .d_vpn(d_vpn),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ipae_h16(ipae_h16), .dpae_h16(dpae_h16), .ipte_h8(ipte_h8), .dpte_h8(dpte_h8),
    .hugepage_ptr(hugepage_ptr), .mmu_enable(mmu_enable), .walk_busy(walk_busy),
    .refill_done(refill_done), .pf_i(pf_i), .pf_d(pf_d)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_en = 1'b0; m_ptbr = '0; m_huge = '0; m_itlb = '0; m_dtlb = '0; m_fault = '0;
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: m_en   = d[0];
      3'd1: m_ptbr = d & 32'hFFFF_FC00;
      3'd2: m_huge = d[10:0];
      3'd3: m_itlb = d[23:0];
      3'd4: m_dtlb = d[23:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {31'b0, m_en};
      3'd1: return m_ptbr;
      3'd2: return {21'b0, m_huge};
      3'd3: return {8'b0, m_itlb};
      3'd4: return {8'b0, m_dtlb};
      3'd5: return {23'b0, m_fault};
      default: return 32'h0;
    endcase
  endfunction

  // Walk result under the architectural rules.
  function automatic void m_walk(input bit side, input logic [7:0] vpn, input logic [31:0] pte,
                                 output bit ok);
    ok = pte[31] && (side || pte[30]);
    if (ok) begin
      if (side) m_dtlb = {vpn, pte[15:0]};
      else      m_itlb = {vpn, pte[15:0]};
    end else begin
      m_fault = {side, vpn};
    end
  endfunction

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_we = 1'b0;
    m_write(a, d);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_en"},   32'(mmu_enable),   32'(m_en));
    check({tag, "_huge"}, 32'(hugepage_ptr), 32'(m_huge));
    check({tag, "_itlb"}, {8'b0, ipte_h8, ipae_h16}, {8'b0, m_itlb});
    check({tag, "_dtlb"}, {8'b0, dpte_h8, dpae_h16}, {8'b0, m_dtlb});
  endtask

  // Reads every CSR index while idle, then realigns to a falling edge.
  task automatic check_regs(input string tag);
    check_outputs(tag);
    for (int a = 0; a < 8; a++) begin
      csr_addr = 3'(a);
      #0.5;
      check($sformatf("%s_csr%0d", tag, a), csr_rdata, m_read(3'(a)));
    end
    @(negedge clk);
  endtask

  task automatic do_walk(input string tag, input bit side, input logic [7:0] vpn,
                         input logic [31:0] pte, input int dly);
    bit ok;
    logic [31:0] exp_addr;
    exp_addr = m_ptbr + 32'(vpn) * 32'd4;
    if (side) begin d_miss = 1'b1; d_vpn = vpn; end
    else      begin i_miss = 1'b1; i_vpn = vpn; end
    @(negedge clk);
    d_miss = 1'b0; i_miss = 1'b0;
    check({tag, "_req"},  32'(mem_req), 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    check({tag, "_busy"}, 32'(walk_busy), 32'd1);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {29'b0, mem_req, refill_done, pf_i | pf_d}, 32'b100);
    end
    mem_ack = 1'b1; mem_rdata = pte;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    m_walk(side, vpn, pte, ok);
    check({tag, "_pulse"}, {29'b0, refill_done, pf_i, pf_d},
          {29'b0, ok, !ok && !side, !ok && side});
    check({tag, "_donereq"}, {30'b0, walk_busy, mem_req}, 32'b10);
    check_outputs(tag);
    @(negedge clk);
    check({tag, "_idle"}, {28'b0, walk_busy, refill_done, pf_i, pf_d}, 32'b0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    i_miss = 0; d_miss = 0; i_vpn = 0; d_vpn = 0; mem_ack = 0; mem_rdata = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_outs", {27'b0, mem_req, walk_busy, refill_done, pf_i, pf_d}, 32'b0);
    check("rst_addr", mem_addr, 32'h0);
    check_regs("rst");

    // Basic data refill
    csr_write(3'd0, 32'h1);
    csr_write(3'd1, 32'h0001_2400);
    do_walk("tp1", 1'b1, 8'h5A, 32'h8000_BEEF, 2);
    check("tp1_dpae", 32'(dpae_h16), 32'h0000_BEEF);
    check("tp1_dpte", 32'(dpte_h8), 32'h0000_005A);

    // Instruction side: X=0 faults, X=1 refills
    do_walk("tp2", 1'b0, 8'h03, 32'h8000_1234, 0);
    csr_addr = 3'd5; #0.5;
    check("tp2_fault", csr_rdata, 32'h0000_0003);
    check("tp2_ipae_unch", 32'(ipae_h16), 32'h0);
    do_walk("tp3", 1'b0, 8'h03, 32'hC000_1234, 1);
    check("tp3_itlb", {8'b0, ipte_h8, ipae_h16}, 32'h0003_1234);

    // Simultaneous misses: data first, instruction walk follows
    d_miss = 1; d_vpn = 8'h11; i_miss = 1; i_vpn = 8'h22;
    @(negedge clk);
    d_miss = 0;
    check("pri_addr_d", mem_addr, m_ptbr + 32'h44);
    mem_ack = 1; mem_rdata = 32'h8000_0101;
    @(negedge clk);
    mem_ack = 0;
    m_walk(1'b1, 8'h11, 32'h8000_0101, ok);
    check("pri_done_d", 32'(refill_done), 32'd1);
    check("pri_dtlb", {8'b0, dpte_h8, dpae_h16}, {8'b0, m_dtlb});
    @(negedge clk);
    check("pri_gap", {30'b0, walk_busy, mem_req}, 32'b0);
    @(negedge clk);
    i_miss = 0;
    check("pri_req_i", 32'(mem_req), 32'd1);
    check("pri_addr_i", mem_addr, m_ptbr + 32'h88);
    mem_ack = 1; mem_rdata = 32'hC000_0202;
    @(negedge clk);
    mem_ack = 0;
    m_walk(1'b0, 8'h22, 32'hC000_0202, ok);
    check("pri_done_i", 32'(refill_done), 32'd1);
    @(negedge clk);
    check_regs("pri");

    // Disable mid-walk: request drains, no update, no pulse
    d_miss = 1; d_vpn = 8'h33;
    @(negedge clk);
    d_miss = 0;
    check("drn_req0", 32'(mem_req), 32'd1);
    csr_write(3'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("drn_hold", {30'b0, mem_req, walk_busy}, 32'b11);
      @(negedge clk);
    end
    mem_ack = 1; mem_rdata = 32'h8000_9999;
    @(negedge clk);
    mem_ack = 0;
    check("drn_end", {27'b0, mem_req, walk_busy, refill_done, pf_i, pf_d}, 32'b0);
    check_regs("drn");

    // Misses ignored while disabled
    d_miss = 1; d_vpn = 8'h44;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("dis_noreq", {30'b0, mem_req, walk_busy}, 32'b0);
    end
    d_miss = 0;

    // Same-edge CSR write beats the walk update
    csr_write(3'd0, 32'h1);
    d_miss = 1; d_vpn = 8'h44;
    @(negedge clk);
    d_miss = 0;
    mem_ack = 1; mem_rdata = 32'h8000_5555;
    csr_we = 1; csr_addr = 3'd4; csr_wdata = 32'h0077_AAAA;
    @(negedge clk);
    mem_ack = 0; csr_we = 0;
    m_walk(1'b1, 8'h44, 32'h8000_5555, ok);
    m_write(3'd4, 32'h0077_AAAA);
    check("col_done", 32'(refill_done), 32'd1);
    csr_addr = 3'd4; #0.5;
    check("col_dtlb", csr_rdata, 32'h0077_AAAA);
    @(negedge clk);
    check_regs("col");

    // Randomized CSR traffic and walks
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        csr_write(3'($urandom_range(0, 7)), $urandom);
      end else begin
        if (!m_en) csr_write(3'd0, 32'h1);
        do_walk("rnd", 1'($urandom_range(0, 1)), 8'($urandom),
                {2'($urandom), 30'($urandom)}, $urandom_range(0, 3));
      end
      check_regs("rnd");
    end

    // Reset during a walk
    if (!m_en) csr_write(3'd0, 32'h1);
    csr_write(3'd1, 32'hABCD_E400);
    d_miss = 1; d_vpn = 8'h77;
    @(negedge clk);
    d_miss = 0;
    check("rstw_req", 32'(mem_req), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_reset();
    check("rstw_outs", {27'b0, mem_req, walk_busy, refill_done, pf_i, pf_d}, 32'b0);
    check("rstw_addr", mem_addr, 32'h0);
    check_regs("rstw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
